// File: rtl/tpu_host_seq.sv
// rtl/tpu_host_seq.sv - host-side sequencer driving the 2x2 TPU pin protocol
module tpu_host_seq #(
    parameter logic [2:0] OP_NOP         = 3'd0,
    parameter logic [2:0] OP_LOAD        = 3'd1,
    parameter logic [2:0] OP_COMPUTE     = 3'd2,
    parameter int         TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       timeout_err,
    output logic [7:0] tpu_instr,
    output logic [7:0] tpu_data,
    input  logic [7:0] tpu_result,
    input  logic       tpu_done
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_VAL = TW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ISSUE, S_WAIT_DONE, S_CAPTURE, S_DRAIN
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    load_cnt_q, load_cnt_d;
    logic [1:0]    cap_idx_q, cap_idx_d;
    logic [1:0]    drain_idx_q, drain_idx_d;
    logic [TW-1:0] timer_q, timer_d, timer_next;
    logic [7:0]    res_buf_q [4];
    logic [7:0]    res_buf_d [4];

    logic       in_ready_d, out_valid_d, busy_d, timeout_err_d;
    logic [7:0] out_data_d, tpu_instr_d, tpu_data_d;
    logic       accept;

    // State and registered outputs; every pin the TPU or host sees comes from a flop
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            load_cnt_q  <= '0;
            cap_idx_q   <= '0;
            drain_idx_q <= '0;
            timer_q     <= '0;
            res_buf_q   <= '{default: 8'h00};
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= 8'h00;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            tpu_instr   <= {5'b0, OP_NOP};
            tpu_data    <= 8'h00;
        end else begin
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            cap_idx_q   <= cap_idx_d;
            drain_idx_q <= drain_idx_d;
            timer_q     <= timer_d;
            res_buf_q   <= res_buf_d;
            in_ready    <= in_ready_d;
            out_valid   <= out_valid_d;
            out_data    <= out_data_d;
            busy        <= busy_d;
            timeout_err <= timeout_err_d;
            tpu_instr   <= tpu_instr_d;
            tpu_data    <= tpu_data_d;
        end
    end

    // Next-state and next-output decode; the instruction defaults to NOP so LOAD/COMPUTE last one cycle
    always_comb begin
        state_d       = state_q;
        load_cnt_d    = load_cnt_q;
        cap_idx_d     = cap_idx_q;
        drain_idx_d   = drain_idx_q;
        timer_d       = timer_q;
        res_buf_d     = res_buf_q;
        out_valid_d   = out_valid;
        out_data_d    = out_data;
        timeout_err_d = timeout_err;
        tpu_instr_d   = {5'b0, OP_NOP};
        tpu_data_d    = tpu_data;
        timer_next    = timer_q + TW'(1);
        accept        = in_valid && in_ready;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    tpu_instr_d   = {5'b0, OP_LOAD};
                    tpu_data_d    = in_data;
                    timeout_err_d = 1'b0;
                    load_cnt_d    = 4'd1;
                    state_d       = S_LOAD;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    tpu_instr_d = {5'b0, OP_LOAD};
                    tpu_data_d  = in_data;
                    load_cnt_d  = load_cnt_q + 4'd1;
                    if (load_cnt_q == 4'd7) begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                tpu_instr_d = {5'b0, OP_COMPUTE};
                timer_d     = '0;
                state_d     = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                // done wins over an expiring timer in the same cycle
                if (tpu_done) begin
                    res_buf_d[0] = tpu_result;
                    cap_idx_d    = 2'd1;
                    timer_d      = '0;
                    state_d      = S_CAPTURE;
                end else if (timer_next == TIMEOUT_VAL) begin
                    timeout_err_d = 1'b1;
                    timer_d       = '0;
                    state_d       = S_IDLE;
                end else begin
                    timer_d = timer_next;
                end
            end
            S_CAPTURE: begin
                // The TPU streams c01, c10, c11 on the cycles after done, whatever done does
                res_buf_d[cap_idx_q] = tpu_result;
                if (cap_idx_q == 2'd3) begin
                    cap_idx_d   = 2'd0;
                    drain_idx_d = 2'd0;
                    out_valid_d = 1'b1;
                    out_data_d  = res_buf_q[0];
                    state_d     = S_DRAIN;
                end else begin
                    cap_idx_d = cap_idx_q + 2'd1;
                end
            end
            S_DRAIN: begin
                if (out_valid && out_ready) begin
                    if (drain_idx_q == 2'd3) begin
                        out_valid_d = 1'b0;
                        drain_idx_d = 2'd0;
                        state_d     = S_IDLE;
                    end else begin
                        drain_idx_d = drain_idx_q + 2'd1;
                        out_data_d  = res_buf_q[drain_idx_q + 2'd1];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // LOAD never holds count 8 (the 8th accept leaves it), so being there implies room
        in_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);
        busy_d     = (state_d != S_IDLE);
    end

endmodule

// File: tb/tb_tpu_host_seq.sv
// tb/tb_tpu_host_seq.sv - directed self-checking bench for tpu_host_seq
module tb_tpu_host_seq;

    localparam logic [7:0] I_NOP  = 8'h00;
    localparam logic [7:0] I_LOAD = 8'h01;
    localparam logic [7:0] I_COMP = 8'h02;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       drv_valid = 1'b0;
    logic [7:0] drv_data = 8'h00;
    logic       noise_en = 1'b0;
    logic       noise_valid = 1'b0;
    logic [7:0] noise_data = 8'h3C;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       busy;
    logic       timeout_err;
    logic [7:0] tpu_instr;
    logic [7:0] tpu_data;
    logic [7:0] tpu_result = 8'h00;
    logic       tpu_done = 1'b0;

    int checks = 0;
    int fails  = 0;
    int acc_cnt = 0;
    int hs_cnt  = 0;
    bit respond_en = 1'b1;
    bit trace_en = 1'b0;
    logic [7:0] tr_instr [$];
    logic [7:0] tr_data [$];
    logic [7:0] got [4];

    assign in_valid = noise_en ? noise_valid : drv_valid;
    assign in_data  = noise_en ? noise_data : drv_data;

    tpu_host_seq dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .timeout_err(timeout_err),
        .tpu_instr(tpu_instr), .tpu_data(tpu_data),
        .tpu_result(tpu_result), .tpu_done(tpu_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (trace_en) begin
            tr_instr.push_back(tpu_instr);
            tr_data.push_back(tpu_data);
        end
    end

    always @(posedge clk) begin
        if (!rst && in_valid && in_ready) acc_cnt++;
        if (!rst && out_valid && out_ready) hs_cnt++;
    end

    always @(negedge clk) begin
        noise_valid = busy;
        noise_data  = noise_data + 8'd7;
    end

    // TPU model: done 6 cycles after COMPUTE, then c00,c01,c10,c11 on consecutive cycles
    always begin
        @(negedge clk);
        if (respond_en && tpu_instr == I_COMP) begin
            repeat (6) @(negedge clk);
            tpu_done = 1'b1; tpu_result = 8'd19; @(negedge clk);
            tpu_done = 1'b0; tpu_result = 8'd22; @(negedge clk);
            tpu_result = 8'd43; @(negedge clk);
            tpu_result = 8'd50; @(negedge clk);
            tpu_result = 8'd0;
        end
    end

    task automatic send_bytes(input int nbytes, input int gap, output bit to);
        int n;
        to = 1'b0;
        for (int i = 0; i < nbytes; i++) begin
            drv_valid = 1'b1;
            drv_data  = 8'(i + 1);
            n = 0;
            while (!in_ready && n < 100) begin @(negedge clk); n++; end
            if (!in_ready) begin to = 1'b1; drv_valid = 1'b0; return; end
            @(negedge clk);
            drv_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic collect(input int stall, output bit to, output bit hold_bad);
        int n;
        logic [7:0] held;
        to = 1'b0;
        hold_bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!out_valid && n < 300) begin @(negedge clk); n++; end
            if (!out_valid) begin to = 1'b1; return; end
            held = out_data;
            for (int s = 0; s < stall; s++) begin
                out_ready = 1'b0;
                @(negedge clk);
                if (out_valid !== 1'b1 || out_data !== held) hold_bad = 1'b1;
            end
            got[k] = out_data;
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    task automatic trace_errors(input int gap, output int errs);
        int p, idx, c;
        p = -1;
        errs = 0;
        for (int i = 0; i < tr_instr.size(); i++) begin
            if (tr_instr[i] == I_LOAD) begin p = i; break; end
        end
        if (p < 0) begin errs = 1; return; end
        for (int i = 0; i < 8; i++) begin
            idx = p + i * (gap + 1);
            if (idx >= tr_instr.size()) errs++;
            else if (tr_instr[idx] != I_LOAD || tr_data[idx] != 8'(i + 1)) errs++;
            if (i < 7) begin
                for (int g = 1; g <= gap; g++) begin
                    if (idx + g >= tr_instr.size()) errs++;
                    else if (tr_instr[idx + g] != I_NOP || tr_data[idx + g] != 8'(i + 1)) errs++;
                end
            end
        end
        c = p + 7 * (gap + 1) + 1;
        if (c + 1 >= tr_instr.size()) errs++;
        else if (tr_instr[c] != I_COMP || tr_instr[c + 1] != I_NOP) errs++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin fails++; $display("FAIL reset_out_data: got %h want 00", out_data); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
        checks++; if (tpu_instr !== I_NOP) begin fails++; $display("FAIL reset_tpu_instr: got %h want 00", tpu_instr); end
        checks++; if (tpu_data !== 8'h00) begin fails++; $display("FAIL reset_tpu_data: got %h want 00", tpu_data); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL idle_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic run_txn(input string name, input int gap);
        bit to, to2, hb;
        int errs;
        tr_instr.delete(); tr_data.delete(); trace_en = 1'b1;
        send_bytes(8, gap, to);
        checks++; if (to !== 1'b0) begin fails++; $display("FAIL %s_send: in_ready timeout", name); end
        collect(0, to2, hb);
        checks++; if (to2 !== 1'b0) begin fails++; $display("FAIL %s_collect: out_valid timeout", name); end
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL %s_end: busy=%b out_valid=%b want 0 0", name, busy, out_valid); end
        checks++; if (got[0] !== 8'd19 || got[1] !== 8'd22 || got[2] !== 8'd43 || got[3] !== 8'd50) begin
            fails++; $display("FAIL %s_results: got %0d %0d %0d %0d want 19 22 43 50", name, got[0], got[1], got[2], got[3]); end
        repeat (2) @(negedge clk);
        trace_en = 1'b0;
        trace_errors(gap, errs);
        checks++; if (errs != 0) begin fails++; $display("FAIL %s_trace: %0d bad cycles want 0", name, errs); end
    endtask

    task automatic test_back_to_back();
        run_txn("b2b", 0);
    endtask

    task automatic test_gapped();
        run_txn("gap", 1);
    endtask

    task automatic test_drain_stall();
        bit to, to2, hb, ov;
        int hs0;
        hs0 = hs_cnt;
        send_bytes(8, 0, to);
        collect(3, to2, hb);
        checks++; if (to !== 1'b0 || to2 !== 1'b0) begin fails++; $display("FAIL stall_timeout: send=%b collect=%b want 0 0", to, to2); end
        checks++; if (hb !== 1'b0) begin fails++; $display("FAIL stall_hold: out_data/out_valid changed while stalled"); end
        checks++; if (got[0] !== 8'd19 || got[1] !== 8'd22 || got[2] !== 8'd43 || got[3] !== 8'd50) begin
            fails++; $display("FAIL stall_results: got %0d %0d %0d %0d want 19 22 43 50", got[0], got[1], got[2], got[3]); end
        ov = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin if (out_valid) ov = 1'b1; @(negedge clk); end
        out_ready = 1'b0;
        checks++; if (ov !== 1'b0) begin fails++; $display("FAIL stall_extra_valid: out_valid seen after 4th handshake"); end
        checks++; if (hs_cnt - hs0 != 4) begin fails++; $display("FAIL stall_handshakes: got %0d want 4", hs_cnt - hs0); end
    endtask

    task automatic test_timeout();
        bit to, ov;
        int n, cyc;
        respond_en = 1'b0;
        send_bytes(8, 0, to);
        n = 0;
        while (tpu_instr !== I_COMP && n < 10) begin @(negedge clk); n++; end
        checks++; if (tpu_instr !== I_COMP) begin fails++; $display("FAIL to_compute: got %h want 02", tpu_instr); end
        cyc = 0; ov = 1'b0;
        while (timeout_err !== 1'b1 && cyc < 200) begin
            @(negedge clk); cyc++;
            if (out_valid) ov = 1'b1;
        end
        checks++; if (cyc != 64) begin fails++; $display("FAIL to_latency: got %0d cycles want 64", cyc); end
        checks++; if (ov !== 1'b0) begin fails++; $display("FAIL to_out_valid: out_valid seen during timeout"); end
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL to_idle: busy=%b in_ready=%b want 0 1", busy, in_ready); end
        repeat (3) @(negedge clk);
        checks++; if (timeout_err !== 1'b1) begin fails++; $display("FAIL to_sticky: got %b want 1", timeout_err); end
        drv_valid = 1'b1; drv_data = 8'h55;
        @(negedge clk);
        drv_valid = 1'b0;
        checks++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL to_clear: got %b want 0", timeout_err); end
        checks++; if (tpu_instr !== I_LOAD || tpu_data !== 8'h55) begin fails++; $display("FAIL to_reload: instr=%h data=%h want 01 55", tpu_instr, tpu_data); end
        rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
        respond_en = 1'b1;
    endtask

    task automatic test_reset_midload();
        bit to;
        int bad;
        send_bytes(5, 0, to);
        checks++; if (tpu_instr !== I_LOAD || tpu_data !== 8'd5) begin fails++; $display("FAIL mid_load5: instr=%h data=%h want 01 05", tpu_instr, tpu_data); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (tpu_instr !== I_NOP || busy !== 1'b0) begin fails++; $display("FAIL mid_reset: instr=%h busy=%b want 00 0", tpu_instr, busy); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL mid_idle: in_ready=%b busy=%b want 1 0", in_ready, busy); end
        bad = 0;
        for (int i = 0; i < 12; i++) begin if (tpu_instr !== I_NOP) bad++; @(negedge clk); end
        checks++; if (bad != 0) begin fails++; $display("FAIL mid_quiet: %0d non-NOP cycles want 0", bad); end
        run_txn("mid_fresh", 0);
    endtask

    task automatic test_busy_ignore();
        bit to, to2, hb;
        int acc0;
        send_bytes(8, 0, to);
        acc0 = acc_cnt;
        noise_en = 1'b1;
        collect(2, to2, hb);
        noise_en = 1'b0;
        @(negedge clk);
        checks++; if (acc_cnt != acc0) begin fails++; $display("FAIL ign_accepts: got %0d extra want 0", acc_cnt - acc0); end
        checks++; if (to !== 1'b0 || to2 !== 1'b0) begin fails++; $display("FAIL ign_timeout: send=%b collect=%b want 0 0", to, to2); end
        checks++; if (got[0] !== 8'd19 || got[1] !== 8'd22 || got[2] !== 8'd43 || got[3] !== 8'd50) begin
            fails++; $display("FAIL ign_results: got %0d %0d %0d %0d want 19 22 43 50", got[0], got[1], got[2], got[3]); end
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL ign_idle: busy=%b in_ready=%b want 0 1", busy, in_ready); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gapped();
        test_drain_stall();
        test_timeout();
        test_reset_midload();
        test_busy_ignore();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
